// File: rtl/seg_mmio_ctrl.sv
// Bus-mapped controller for an eight-digit 7-segment display: VALUE/MASK/CTRL/DIV
// registers, leading-zero blanking and a blink phase generator with registered digit outputs.
module seg_mmio_ctrl #(
    parameter int                CNT_W         = 24,
    parameter logic [CNT_W-1:0]  BLINK_DIV_RST = 24'd12_499_999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [7:0]  digit_ena,
    output logic [31:0] digit_val
);

    localparam logic [1:0] A_VALUE = 2'd0;
    localparam logic [1:0] A_MASK  = 2'd1;
    localparam logic [1:0] A_CTRL  = 2'd2;
    localparam logic [1:0] A_DIV   = 2'd3;

    logic [31:0]      value;
    logic [7:0]       mask;
    logic [1:0]       ctrl;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic             phase;

    logic        accept;
    logic        wr;
    logic [2:0]  hi;
    logic [7:0]  lz_keep;
    logic [7:0]  keep;
    logic [31:0] rd_mux;

    // The cycle carrying ack never accepts, so a held req cannot double-fire.
    assign accept = req & ~ack;
    assign wr     = accept & we;

    always_comb begin
        hi = 3'd0;
        for (int i = 0; i < 8; i++)
            if (value[4*i +: 4] != 4'h0) hi = 3'(i);
        for (int i = 0; i < 8; i++)
            lz_keep[i] = (3'(i) <= hi);
    end

    assign keep = ctrl[0] ? lz_keep : 8'hFF;

    always_comb begin
        case (addr)
            A_VALUE: rd_mux = value;
            A_MASK:  rd_mux = {24'd0, mask};
            A_CTRL:  rd_mux = {30'd0, ctrl};
            default: rd_mux = 32'(div);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value     <= 32'd0;
            mask      <= 8'hFF;
            ctrl      <= 2'd0;
            div       <= BLINK_DIV_RST;
            cnt       <= '0;
            phase     <= 1'b0;
            ack       <= 1'b0;
            rdata     <= 32'd0;
            digit_ena <= 8'd0;
            digit_val <= 32'd0;
        end else begin
            ack <= accept;
            if (accept && !we) rdata <= rd_mux;

            if (wr) begin
                case (addr)
                    A_VALUE: value <= wdata;
                    A_MASK:  mask  <= wdata[7:0];
                    A_CTRL:  ctrl  <= wdata[1:0];
                    default: div   <= wdata[CNT_W-1:0];
                endcase
            end

            // Blink timing uses the pre-write CTRL; a count above DIV simply wraps.
            if (!ctrl[1]) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (cnt == div) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt   <= cnt + 1'b1;
            end
            if (wr && addr == A_DIV) begin
                cnt   <= '0;
                phase <= 1'b0;
            end

            digit_ena <= mask & keep & {8{~(ctrl[1] & phase)}};
            digit_val <= value;
        end
    end

endmodule

// File: tb/tb_seg_mmio_ctrl.sv
// Scoreboard bench for seg_mmio_ctrl: directed plan items, then random bus traffic
// checked every cycle against an elapsed-time reference model.
module tb_seg_mmio_ctrl;

    localparam logic [23:0] DIV_RST = 24'd12_499_999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic        ack;
    logic [31:0] rdata;
    logic [7:0]  digit_ena;
    logic [31:0] digit_val;

    seg_mmio_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .digit_ena(digit_ena), .digit_val(digit_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int passed = 0;
    int n_ack = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: registers plus cycles elapsed since the blink counter was last cleared.
    logic [31:0] m_value = 32'd0;
    logic [7:0]  m_mask = 8'hFF;
    logic [1:0]  m_ctrl = 2'd0;
    logic [23:0] m_div = DIV_RST;
    longint      m_elapsed = 0;
    bit          m_ack = 1'b0;
    logic [7:0]  exp_ena = 8'd0;
    logic [31:0] exp_val = 32'd0;

    function automatic logic [7:0] model_ena();
        int  h = 0;
        bit  ph;
        logic [7:0] r;
        ph = ((m_elapsed / (longint'(m_div) + 1)) % 2) == 1;
        for (int i = 0; i < 8; i++)
            if (m_value[4*i +: 4] != 4'h0) h = i;
        for (int i = 0; i < 8; i++)
            r[i] = m_mask[i] && (!m_ctrl[0] || i <= h) && !(m_ctrl[1] && ph);
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_value;
            2'd1:    return {24'd0, m_mask};
            2'd2:    return {30'd0, m_ctrl};
            default: return {8'd0, m_div};
        endcase
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            m_value = 32'd0; m_mask = 8'hFF; m_ctrl = 2'd0; m_div = DIV_RST;
            m_elapsed = 0; m_ack = 1'b0; exp_ena = 8'd0; exp_val = 32'd0;
        end else begin
            exp_ena = model_ena();
            exp_val = m_value;
            acc = req && !m_ack;
            if (m_ctrl[1]) m_elapsed++;
            else m_elapsed = 0;
            if (acc && we) begin
                case (addr)
                    2'd0: m_value = wdata;
                    2'd1: m_mask = wdata[7:0];
                    2'd2: m_ctrl = wdata[1:0];
                    default: begin m_div = wdata[23:0]; m_elapsed = 0; end
                endcase
            end
            m_ack = acc;
        end
    end

    // Monitor: per-cycle output compare plus scoreboard pop on every ack.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("ack", {31'd0, ack}, {31'd0, m_ack});
            chk("digit_val", digit_val, exp_val);
            chk("digit_ena", {24'd0, digit_ena}, {24'd0, exp_ena});
            if (ack === 1'b1) begin
                n_ack++;
                if (q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (!e.w) chk("rdata", rdata, e.data);
                end
            end
        end
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] rexp, input bit hold);
        bit got = 1'b0;
        q.push_back('{w, rexp});
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) begin
            chk("ack_timeout", 32'd0, 32'd1);
            q.delete();
        end
        if (hold) @(negedge clk);
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a0, ff_cnt, z_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        rst_n = 1'b1;
        idle(2);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_val", digit_val, 32'd0);
        chk("rst_ena", {24'd0, digit_ena}, 32'hFF);
        a0 = n_ack;
        bus(1'b0, 2'd3, 32'd0, 32'h00BE_BC1F, 1'b0);
        idle(2);
        chk("div_read_one_ack", n_ack - a0, 1);

        a0 = n_ack;
        bus(1'b1, 2'd0, 32'h1234_ABCD, 32'd0, 1'b1);
        idle(2);
        chk("held_req_one_ack", n_ack - a0, 1);
        chk("val_1234abcd", digit_val, 32'h1234_ABCD);
        bus(1'b0, 2'd0, 32'd0, 32'h1234_ABCD, 1'b0);

        bus(1'b1, 2'd0, 32'h0000_0A05, 32'd0, 1'b0);
        bus(1'b1, 2'd2, 32'd1, 32'd0, 1'b0);
        idle(1);
        chk("lzb_a05", {24'd0, digit_ena}, 32'h07);
        bus(1'b1, 2'd0, 32'd0, 32'd0, 1'b0);
        idle(1);
        chk("lzb_zero", {24'd0, digit_ena}, 32'h01);
        bus(1'b1, 2'd1, 32'hFE, 32'd0, 1'b0);
        idle(1);
        chk("lzb_mask_fe", {24'd0, digit_ena}, 32'h00);
        bus(1'b1, 2'd1, 32'hFF, 32'd0, 1'b0);

        bus(1'b1, 2'd3, 32'd3, 32'd0, 1'b0);
        bus(1'b1, 2'd2, 32'd2, 32'd0, 1'b0);
        idle(2);
        ff_cnt = 0; z_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (digit_ena == 8'hFF) ff_cnt++;
            if (digit_ena == 8'h00) z_cnt++;
        end
        chk("blink_on_cycles", ff_cnt, 8);
        chk("blink_off_cycles", z_cnt, 8);
        bus(1'b1, 2'd2, 32'd0, 32'd0, 1'b0);
        idle(1);
        chk("blink_stop", {24'd0, digit_ena}, 32'hFF);
        idle(8);
        chk("blink_stays_off", {24'd0, digit_ena}, 32'hFF);

        bus(1'b1, 2'd1, 32'hFFFF_FF5A, 32'd0, 1'b0);
        bus(1'b0, 2'd1, 32'd0, 32'h0000_005A, 1'b0);
        chk("mask_5a_ena", {24'd0, digit_ena}, 32'h5A);
        bus(1'b1, 2'd2, 32'hFFFF_FFFC, 32'd0, 1'b0);
        bus(1'b0, 2'd2, 32'd0, 32'd0, 1'b0);

        bus(1'b1, 2'd3, 32'd2, 32'd0, 1'b0);
        bus(1'b1, 2'd2, 32'd2, 32'd0, 1'b0);
        idle(5);
        req = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        chk("rst_mid_ack", {31'd0, ack}, 32'd0);
        idle(2);
        chk("rst_mid_ena", {24'd0, digit_ena}, 32'hFF);
        bus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        bus(1'b0, 2'd3, 32'd0, 32'h00BE_BC1F, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [1:0]  a;
            logic        w;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            case (a)
                2'd0: d = $urandom >> (4 * $urandom_range(0, 8));
                2'd3: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
                default: d = $urandom;
            endcase
            bus(w, a, d, w ? 32'd0 : model_read(a), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end
        idle(4);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
